data_sram_responder: RTL and testbench



---
 rtl/data_sram_responder_if.sv | 23 ++
 rtl/data_sram_responder.sv | 142 ++++++++++++++
 tb/tb_data_sram_responder.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_responder_if.sv
// Request/response handshake bundle between a load/store requester and the data SRAM responder.
interface data_sram_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [3:0]  req_strobe;
    logic [31:0] req_address;
    logic [31:0] req_write_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_read_data;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_strobe, req_address, req_write_data, resp_ready,
        input  req_ready, resp_valid, resp_read_data, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_strobe, req_address, req_write_data, resp_ready,
        output req_ready, resp_valid, resp_read_data, resp_error
    );
endinterface

// File: rtl/data_sram_responder.sv
// Word-organised data SRAM with byte-lane stores, fixed response latency and one request in flight.
module data_sram_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    data_sram_responder_if.slave  bus
);
    localparam int         DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RESPOND = 2'd2;
    localparam logic [2:0] LOAD_COUNT = 3'(LATENCY - 1);

    logic [31:0]           mem_r [0:DEPTH-1];
    logic [1:0]            state_r;
    logic [1:0]            state_s;
    logic [2:0]            count_r;
    logic [2:0]            count_s;
    logic                  write_r;
    logic                  range_err_r;
    logic [ADDR_WIDTH-1:0] index_r;
    logic                  resp_valid_r;
    logic [31:0]           read_data_r;
    logic                  error_r;

    logic                  req_ready_s;
    logic                  accept_s;
    logic                  req_error_s;
    logic [ADDR_WIDTH-1:0] req_index_s;
    logic                  enter_respond_s;
    logic [ADDR_WIDTH-1:0] read_index_s;
    logic                  read_write_s;
    logic                  read_error_s;
    logic [31:0]           read_data_s;
    logic                  unused_s;

    assign req_ready_s = (state_r == ST_IDLE) | ((state_r == ST_RESPOND) & bus.resp_ready);
    // Nothing is accepted while reset is held, so a store presented during reset never lands.
    assign accept_s    = bus.req_valid & req_ready_s & reset;
    assign req_error_s = |bus.req_address[31:ADDR_WIDTH+2];
    assign req_index_s = bus.req_address[ADDR_WIDTH+1:2];
    assign unused_s    = ^bus.req_address[1:0];

    assign bus.req_ready      = req_ready_s;
    assign bus.resp_valid     = resp_valid_r;
    assign bus.resp_read_data = read_data_r;
    assign bus.resp_error     = error_r;

    // Next state and countdown of the request FSM.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        if (accept_s) begin
            state_s = (LATENCY == 1) ? ST_RESPOND : ST_WAIT;
            count_s = LOAD_COUNT;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_WAIT: begin
                    if (count_r == 3'd1) begin
                        state_s = ST_RESPOND;
                        count_s = 3'd0;
                    end else begin
                        count_s = count_r - 3'd1;
                    end
                end
                ST_RESPOND: begin
                    if (bus.resp_ready) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_RESPOND;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    count_s = 3'd0;
                end
            endcase
        end
    end

    // At LATENCY 1 the accept edge is also the edge entering RESPOND, so read straight from the request.
    always_comb begin
        enter_respond_s = (accept_s && (LATENCY == 1)) || ((state_r == ST_WAIT) && (count_r == 3'd1));
        if (accept_s) begin
            read_index_s = req_index_s;
            read_write_s = bus.req_write;
            read_error_s = req_error_s;
        end else begin
            read_index_s = index_r;
            read_write_s = write_r;
            read_error_s = range_err_r;
        end
        if (read_write_s || read_error_s) begin
            read_data_s = 32'h0000_0000;
        end else begin
            read_data_s = mem_r[read_index_s];
        end
    end

    // Control state, request capture and registered response.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            count_r      <= 3'd0;
            write_r      <= 1'b0;
            range_err_r  <= 1'b0;
            index_r      <= '0;
            resp_valid_r <= 1'b0;
            read_data_r  <= 32'h0000_0000;
            error_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            count_r      <= count_s;
            resp_valid_r <= (state_s == ST_RESPOND);
            if (accept_s) begin
                write_r     <= bus.req_write;
                range_err_r <= req_error_s;
                index_r     <= req_index_s;
            end
            if (enter_respond_s) begin
                read_data_r <= read_data_s;
                error_r     <= read_error_s;
            end
        end
    end

    // Storage array: written on the accept edge, never cleared by reset.
    always_ff @(posedge clock) begin
        if (accept_s && bus.req_write && !req_error_s) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_strobe[i]) begin
                    mem_r[req_index_s][8*i +: 8] <= bus.req_write_data[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// Three responders (LATENCY 1, 3, 4) share one driver; the selected one is checked against a transaction model.
module tb_data_sram_responder;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        drv_valid;
    logic        drv_write;
    logic [3:0]  drv_strobe;
    logic [31:0] drv_address;
    logic [31:0] drv_wdata;
    logic        drv_resp_ready;
    int          sel;

    logic [2:0]  obs_valid_v;
    logic [2:0]  obs_ready_v;
    logic [2:0]  obs_err_v;
    logic [31:0] obs_data_v [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_sram_responder_if bus ();
        assign bus.req_valid      = drv_valid && (sel == g);
        assign bus.req_write      = drv_write;
        assign bus.req_strobe     = drv_strobe;
        assign bus.req_address    = drv_address;
        assign bus.req_write_data = drv_wdata;
        assign bus.resp_ready     = drv_resp_ready && (sel == g);
        data_sram_responder #(
            .ADDR_WIDTH(10),
            .LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) dut (
            .clock(clock),
            .reset(reset),
            .bus(bus)
        );
        assign obs_valid_v[g] = bus.resp_valid;
        assign obs_ready_v[g] = bus.req_ready;
        assign obs_err_v[g]   = bus.resp_error;
        assign obs_data_v[g]  = bus.resp_read_data;
    end

    // Transaction-level model: memory image per instance plus the single outstanding response.
    logic [31:0] mem_m [3][1024];
    bit          pending;
    int          remaining;
    logic [31:0] exp_data;
    bit          exp_err;
    int          since_acc;
    int          dut_lat;
    bit          lat_seen;
    logic [31:0] ret_data;
    logic        ret_err;
    bit          accepted;
    int          errors = 0;
    int          checks = 0;

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (dut %0d, t=%0t): got %h expected %h", name, sel, $time, act, exp);
        end
    endtask

    task automatic apply_model(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int          idx;
        logic [31:0] word;
        idx = int'(a[11:2]);
        if (a[31:12] != 20'h0) begin
            exp_err  = 1'b1;
            exp_data = 32'h0;
        end else if (w) begin
            exp_err = 1'b0;
            word    = mem_m[sel][idx];
            for (int i = 0; i < 4; i++) begin
                if (s[i]) word[8*i +: 8] = d[8*i +: 8];
            end
            mem_m[sel][idx] = word;
            exp_data = 32'h0;
        end else begin
            exp_err  = 1'b0;
            exp_data = mem_m[sel][idx];
        end
    endtask

    // One clock cycle: starts and ends at a falling edge, compares every output against the model.
    task automatic cycle(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit rr);
        bit visible;
        bit exp_ready;
        drv_valid = v; drv_write = w; drv_address = a; drv_wdata = d; drv_strobe = s; drv_resp_ready = rr;
        #1;
        visible   = pending && (remaining == 0);
        exp_ready = !pending || (visible && rr);
        check("req_ready", {31'h0, obs_ready_v[sel]}, {31'h0, exp_ready});
        accepted = 1'b0;
        if (visible && rr) begin
            pending  = 1'b0;
            ret_data = obs_data_v[sel];
            ret_err  = obs_err_v[sel];
        end
        if (v && exp_ready) begin
            accepted = 1'b1;
            apply_model(w, a, d, s);
            pending   = 1'b1;
            remaining = lat_of(sel);
            since_acc = 0;
            lat_seen  = 1'b0;
        end
        @(negedge clock);
        since_acc++;
        if (pending && remaining > 0) remaining--;
        check("resp_valid", {31'h0, obs_valid_v[sel]}, {31'h0, (pending && remaining == 0)});
        if (pending && remaining == 0) begin
            check("resp_read_data", obs_data_v[sel], exp_data);
            check("resp_error", {31'h0, obs_err_v[sel]}, {31'h0, exp_err});
        end
        if (obs_valid_v[sel] && !lat_seen) begin
            lat_seen = 1'b1;
            dut_lat  = since_acc;
        end
    endtask

    task automatic drain();
        int budget = 0;
        while (pending && budget < 20) begin
            cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
            budget++;
        end
        if (pending) check("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int budget = 0;
        cycle(1'b1, w, a, d, s, 1'b1);
        while (!accepted && budget < 20) begin
            cycle(1'b1, w, a, d, s, 1'b1);
            budget++;
        end
        if (!accepted) check("accept_timeout", 32'd1, 32'd0);
        drain();
    endtask

    // Reset held for n cycles while a store to address a is being offered.
    task automatic do_reset(input int n, input logic [31:0] a);
        reset = 1'b0;
        drv_valid = 1'b1; drv_write = 1'b1; drv_address = a; drv_wdata = 32'hBAD0_BAD0;
        drv_strobe = 4'hF; drv_resp_ready = 1'b1;
        repeat (n) begin
            @(negedge clock);
            check("resp_valid_in_reset", {31'h0, obs_valid_v[sel]}, 32'd0);
        end
        reset = 1'b1;
        drv_valid = 1'b0;
        pending  = 1'b0;
        lat_seen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          hold;
        bit          hv;
        bit          hw;
        bit          rr;
        logic [31:0] ha;
        logic [31:0] hd;
        logic [3:0]  hs;
        int          vis_count;

        sel = 0; pending = 1'b0; remaining = 0; accepted = 1'b0; lat_seen = 1'b0;
        drv_valid = 1'b0; drv_write = 1'b0; drv_address = 32'h0; drv_wdata = 32'h0;
        drv_strobe = 4'h0; drv_resp_ready = 1'b0;
        do_reset(2, 32'h10);
        for (int g = 0; g < 3; g++) begin
            sel = g;
            check("reset_read_data", obs_data_v[g], 32'h0);
            check("reset_error", {31'h0, obs_err_v[g]}, 32'd0);
        end

        for (int g = 0; g < 3; g++) begin
            sel = g;
            for (int k = 0; k < 8; k++) do_req(1'b1, 32'(k * 4), 32'hC0DE_0000 | 32'(k), 4'hF);

            // Store offered under reset must not land.
            do_reset(2, 32'h10);
            do_req(1'b0, 32'h10, 32'h0, 4'h0);
            check("reset_no_write", ret_data, 32'hC0DE_0004);

            if (g == 1) begin
                do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
                do_req(1'b0, 32'h10, 32'h0, 4'h0);
                check("load_latency3", 32'(dut_lat), 32'd3);
                check("load_data", ret_data, 32'hDEAD_BEEF);
                check("load_error", {31'h0, ret_err}, 32'd0);

                cycle(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
                vis_count = 0;
                while (!obs_valid_v[sel] && vis_count < 20) begin
                    cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
                    vis_count++;
                end
                for (int i = 0; i < 5; i++) begin
                    cycle(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
                    check("bp_accepted", {31'h0, accepted}, 32'd0);
                    check("bp_valid", {31'h0, obs_valid_v[sel]}, 32'd1);
                    check("bp_data", obs_data_v[sel], 32'hDEAD_BEEF);
                end
                cycle(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
                check("bp_release_accept", {31'h0, accepted}, 32'd1);
                check("bp_release_data", ret_data, 32'hDEAD_BEEF);
                drain();

                do_req(1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF);
                check("oor_error", {31'h0, ret_err}, 32'd1);
                check("oor_data", ret_data, 32'h0);
                do_req(1'b0, 32'h0, 32'h0, 4'h0);
                check("oor_no_write", ret_data, 32'hC0DE_0000);
            end else if (g == 0) begin
                do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
                cycle(1'b1, 1'b1, 32'h10, 32'h0000_AA00, 4'b0010, 1'b1);
                cycle(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
                check("b2b_accept", {31'h0, accepted}, 32'd1);
                drain();
                check("partial_store", ret_data, 32'hDEAD_AAEF);
            end else begin
                do_req(1'b1, 32'h18, 32'hA5A5_5A5A, 4'hF);
                cycle(1'b1, 1'b0, 32'h18, 32'h0, 4'h0, 1'b1);
                cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
                do_reset(1, 32'h18);
                vis_count = 0;
                for (int i = 0; i < 6; i++) begin
                    cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
                    if (obs_valid_v[sel]) vis_count++;
                end
                check("reset_discard", 32'(vis_count), 32'd0);
                do_req(1'b0, 32'h18, 32'h0, 4'h0);
                check("reset_keeps_store", ret_data, 32'hA5A5_5A5A);
            end

            hold = 1'b0;
            hv = 1'b0; hw = 1'b0; ha = 32'h0; hd = 32'h0; hs = 4'h0;
            repeat (300) begin
                if (!hold) begin
                    hv = ($urandom_range(0, 3) != 0);
                    hw = 1'($urandom_range(0, 1));
                    hd = $urandom;
                    hs = 4'($urandom_range(0, 15));
                    ha = {20'h0, 8'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
                    ha[4:2] = 3'($urandom_range(0, 7));
                    if ($urandom_range(0, 7) == 0) ha[31:12] = 20'($urandom_range(1, 20'hFFFFF));
                end
                rr = ($urandom_range(0, 9) < 7);
                cycle(hv, hw, ha, hd, hs, rr);
                hold = hv && !accepted;
            end
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
